// File: rtl/gradient_calc_pipe.sv
// rtl/gradient_calc_pipe.sv - 4-stage 3x3 Sobel/Prewitt gradient pipeline with magnitude, direction and edge count
// Controls ride with each beat; one global advance stalls every stage together.
module gradient_calc_pipe #(
    parameter  int PIX_W = 8,
    parameter  int CNT_W = 20,
    localparam int G_W   = PIX_W + 3,
    localparam int MAG_W = PIX_W + 3
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic [9*PIX_W-1:0] win_in,
    input  logic               in_valid,
    input  logic               in_sof,
    output logic               in_ready,
    input  logic               kernel_sel,
    input  logic               mag_mode,
    input  logic [MAG_W-1:0]   thresh,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MAG_W-1:0]   mag_out,
    output logic [1:0]         dir_out,
    output logic               edge_out,
    output logic               out_sof,
    output logic [CNT_W-1:0]   edge_count
);
    localparam int SQ_W = 2 * MAG_W;
    localparam int DP_W = MAG_W + 9;

    function automatic logic signed [G_W-1:0] wgt(input logic signed [G_W-1:0] d, input logic prewitt);
        return prewitt ? d : (d <<< 1);
    endfunction

    function automatic logic [MAG_W-1:0] absv(input logic signed [G_W-1:0] v);
        return v[G_W-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    // Greedy bit-by-bit floor square root; t*t never exceeds SQ_W bits.
    function automatic logic [MAG_W-1:0] isqrt(input logic [SQ_W-1:0] x);
        logic [MAG_W-1:0] r;
        logic [MAG_W-1:0] t;
        r = '0;
        for (int i = MAG_W - 1; i >= 0; i--) begin
            t = r | (MAG_W'(1) << i);
            if (SQ_W'(t) * SQ_W'(t) <= x) r = t;
        end
        return r;
    endfunction

    logic                      advance;
    logic signed [G_W-1:0]     pix [9];

    logic                      s1_valid_q, s1_valid_d;
    logic [2:0][G_W-1:0]       s1_gx_q, s1_gx_d, s1_gy_q, s1_gy_d;
    logic                      s1_mode_q, s1_mode_d, s1_sof_q, s1_sof_d;
    logic [MAG_W-1:0]          s1_thr_q, s1_thr_d;

    logic                      s2_valid_q, s2_valid_d;
    logic signed [G_W-1:0]     s2_gx_q, s2_gx_d, s2_gy_q, s2_gy_d;
    logic                      s2_mode_q, s2_mode_d, s2_sof_q, s2_sof_d;
    logic [MAG_W-1:0]          s2_thr_q, s2_thr_d;

    logic                      s3_valid_q, s3_valid_d;
    logic [MAG_W-1:0]          s3_l1_q, s3_l1_d;
    logic [SQ_W-1:0]           s3_sq_q, s3_sq_d;
    logic [1:0]                s3_dir_q, s3_dir_d;
    logic                      s3_mode_q, s3_mode_d, s3_sof_q, s3_sof_d;
    logic [MAG_W-1:0]          s3_thr_q, s3_thr_d;

    logic                      out_valid_q, out_valid_d;
    logic [MAG_W-1:0]          mag_q, mag_d;
    logic [1:0]                dir_q, dir_d;
    logic                      edge_q, edge_d, sof_q, sof_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    logic [MAG_W-1:0]          ax, ay;
    logic [MAG_W:0]            l1_sum;
    logic [SQ_W-1:0]           ax_sq, ay_sq;
    logic [DP_W-1:0]           ax_w, ay_w;
    logic [1:0]                dir_c;
    logic [MAG_W-1:0]          mag_c;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            pix[i] = $signed(G_W'(win_in[i*PIX_W +: PIX_W]));
        end
    end

    always_comb begin
        ax     = absv(s2_gx_q);
        ay     = absv(s2_gy_q);
        l1_sum = {1'b0, ax} + {1'b0, ay};
        ax_sq  = SQ_W'(ax) * SQ_W'(ax);
        ay_sq  = SQ_W'(ay) * SQ_W'(ay);
        ax_w   = DP_W'(ax);
        ay_w   = DP_W'(ay);
        // tan(22.5) ~ 106/256 and tan(67.5) ~ 256/106 bound the sectors.
        if ((ay_w << 8) <= ax_w * DP_W'(106)) begin
            dir_c = 2'd0;
        end else if (ay_w * DP_W'(106) > (ax_w << 8)) begin
            dir_c = 2'd2;
        end else if (s2_gx_q[G_W-1] == s2_gy_q[G_W-1]) begin
            dir_c = 2'd1;
        end else begin
            dir_c = 2'd3;
        end
        mag_c = s3_mode_q ? isqrt(s3_sq_q) : s3_l1_q;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_gx_d    = s1_gx_q;
        s1_gy_d    = s1_gy_q;
        s1_mode_d  = s1_mode_q;
        s1_sof_d   = s1_sof_q;
        s1_thr_d   = s1_thr_q;
        s2_valid_d = s2_valid_q;
        s2_gx_d    = s2_gx_q;
        s2_gy_d    = s2_gy_q;
        s2_mode_d  = s2_mode_q;
        s2_sof_d   = s2_sof_q;
        s2_thr_d   = s2_thr_q;
        s3_valid_d = s3_valid_q;
        s3_l1_d    = s3_l1_q;
        s3_sq_d    = s3_sq_q;
        s3_dir_d   = s3_dir_q;
        s3_mode_d  = s3_mode_q;
        s3_sof_d   = s3_sof_q;
        s3_thr_d   = s3_thr_q;
        out_valid_d = out_valid_q;
        mag_d      = mag_q;
        dir_d      = dir_q;
        edge_d     = edge_q;
        sof_d      = sof_q;
        cnt_d      = cnt_q;

        if (advance) begin
            s1_valid_d = in_valid;
            s1_gx_d[0] = pix[2] - pix[0];
            s1_gx_d[1] = wgt(pix[5] - pix[3], kernel_sel);
            s1_gx_d[2] = pix[8] - pix[6];
            s1_gy_d[0] = pix[6] - pix[0];
            s1_gy_d[1] = wgt(pix[7] - pix[1], kernel_sel);
            s1_gy_d[2] = pix[8] - pix[2];
            s1_mode_d  = mag_mode;
            s1_sof_d   = in_sof;
            s1_thr_d   = thresh;

            s2_valid_d = s1_valid_q;
            s2_gx_d    = $signed(s1_gx_q[0]) + $signed(s1_gx_q[1]) + $signed(s1_gx_q[2]);
            s2_gy_d    = $signed(s1_gy_q[0]) + $signed(s1_gy_q[1]) + $signed(s1_gy_q[2]);
            s2_mode_d  = s1_mode_q;
            s2_sof_d   = s1_sof_q;
            s2_thr_d   = s1_thr_q;

            s3_valid_d = s2_valid_q;
            s3_l1_d    = l1_sum[MAG_W] ? '1 : l1_sum[MAG_W-1:0];
            s3_sq_d    = ax_sq + ay_sq;
            s3_dir_d   = dir_c;
            s3_mode_d  = s2_mode_q;
            s3_sof_d   = s2_sof_q;
            s3_thr_d   = s2_thr_q;

            out_valid_d = s3_valid_q;
            mag_d      = mag_c;
            dir_d      = s3_dir_q;
            edge_d     = mag_c > s3_thr_q;
            sof_d      = s3_sof_q;
        end

        // Counter follows the result currently leaving, not the one being loaded.
        if (out_valid_q && out_ready) begin
            if (sof_q) begin
                cnt_d = CNT_W'(edge_q);
            end else if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(edge_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            s1_valid_q  <= 1'b0;
            s1_gx_q     <= '0;
            s1_gy_q     <= '0;
            s1_mode_q   <= 1'b0;
            s1_sof_q    <= 1'b0;
            s1_thr_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_gx_q     <= '0;
            s2_gy_q     <= '0;
            s2_mode_q   <= 1'b0;
            s2_sof_q    <= 1'b0;
            s2_thr_q    <= '0;
            s3_valid_q  <= 1'b0;
            s3_l1_q     <= '0;
            s3_sq_q     <= '0;
            s3_dir_q    <= '0;
            s3_mode_q   <= 1'b0;
            s3_sof_q    <= 1'b0;
            s3_thr_q    <= '0;
            out_valid_q <= 1'b0;
            mag_q       <= '0;
            dir_q       <= '0;
            edge_q      <= 1'b0;
            sof_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_gx_q     <= s1_gx_d;
            s1_gy_q     <= s1_gy_d;
            s1_mode_q   <= s1_mode_d;
            s1_sof_q    <= s1_sof_d;
            s1_thr_q    <= s1_thr_d;
            s2_valid_q  <= s2_valid_d;
            s2_gx_q     <= s2_gx_d;
            s2_gy_q     <= s2_gy_d;
            s2_mode_q   <= s2_mode_d;
            s2_sof_q    <= s2_sof_d;
            s2_thr_q    <= s2_thr_d;
            s3_valid_q  <= s3_valid_d;
            s3_l1_q     <= s3_l1_d;
            s3_sq_q     <= s3_sq_d;
            s3_dir_q    <= s3_dir_d;
            s3_mode_q   <= s3_mode_d;
            s3_sof_q    <= s3_sof_d;
            s3_thr_q    <= s3_thr_d;
            out_valid_q <= out_valid_d;
            mag_q       <= mag_d;
            dir_q       <= dir_d;
            edge_q      <= edge_d;
            sof_q       <= sof_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign mag_out    = mag_q;
    assign dir_out    = dir_q;
    assign edge_out   = edge_q;
    assign out_sof    = sof_q;
    assign edge_count = cnt_q;

endmodule
